// File: rtl/word_splitter_tagged.sv
// rtl/word_splitter_tagged.sv - splits 32-bit words into two tagged 16-bit samples, upper half first
// req/ack on both sides; the stream tag runs round-robin over NR_STREAMS independent of word boundaries.
module word_splitter_tagged #(
  parameter int DWIDTH         = 16,
  parameter int C_SLV_DWIDTH   = 32,
  parameter int NR_STREAMS     = 36,
  parameter int NR_STREAMS_LOG = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      in_req,
  input  logic                      in_ack,
  input  logic [0:C_SLV_DWIDTH-1]   in_data,
  output logic                      out_req,
  input  logic                      out_ack,
  output logic [0:DWIDTH-1]         out_data,
  output logic [NR_STREAMS_LOG-1:0] out_stream,
  output logic                      out_last
);

  if (C_SLV_DWIDTH != 2 * DWIDTH) begin : g_bad_width
    $error("C_SLV_DWIDTH must equal 2*DWIDTH");
  end
  if (NR_STREAMS < 1) begin : g_bad_streams
    $error("NR_STREAMS must be at least 1");
  end
  if ((64'd1 << NR_STREAMS_LOG) < 64'(NR_STREAMS)) begin : g_bad_log
    $error("NR_STREAMS_LOG too small for NR_STREAMS");
  end

  localparam logic [NR_STREAMS_LOG-1:0] LAST_TAG = NR_STREAMS_LOG'(NR_STREAMS - 1);

  typedef enum logic [1:0] {S_EMPTY, S_HI, S_LO} state_t;

  state_t                    r_state;
  logic [0:DWIDTH-1]         r_word_lo;
  logic [0:DWIDTH-1]         r_out_data;
  logic                      r_out_req;
  logic [NR_STREAMS_LOG-1:0] r_stream;
  logic                      r_last;

  logic [NR_STREAMS_LOG-1:0] w_stream_next;
  logic                      w_last_next;
  logic                      w_in_req;

  // r_stream doubles as the frame counter: it always holds the tag of the sample being presented.
  assign w_stream_next = (r_stream == LAST_TAG) ? '0 : r_stream + NR_STREAMS_LOG'(1);
  assign w_last_next   = (w_stream_next == LAST_TAG);

  always_comb begin
    w_in_req = 1'b0;
    if (!rst) begin
      case (r_state)
        S_EMPTY: w_in_req = 1'b1;
        S_LO:    w_in_req = out_ack;
        default: w_in_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_word_lo  <= '0;
      r_out_data <= '0;
      r_out_req  <= 1'b0;
      r_stream   <= '0;
      r_last     <= (NR_STREAMS == 1);
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (in_ack) begin
            r_word_lo  <= in_data[DWIDTH:C_SLV_DWIDTH-1];
            r_out_data <= in_data[0:DWIDTH-1];
            r_out_req  <= 1'b1;
            r_state    <= S_HI;
          end
        end
        S_HI: begin
          if (out_ack) begin
            r_out_data <= r_word_lo;
            r_stream   <= w_stream_next;
            r_last     <= w_last_next;
            r_state    <= S_LO;
          end
        end
        S_LO: begin
          if (out_ack) begin
            r_stream <= w_stream_next;
            r_last   <= w_last_next;
            if (in_ack) begin
              r_word_lo  <= in_data[DWIDTH:C_SLV_DWIDTH-1];
              r_out_data <= in_data[0:DWIDTH-1];
              r_state    <= S_HI;
            end else begin
              r_out_req <= 1'b0;
              r_state   <= S_EMPTY;
            end
          end
        end
        default: begin
          r_out_req <= 1'b0;
          r_state   <= S_EMPTY;
        end
      endcase
    end
  end

  assign in_req     = w_in_req;
  assign out_req    = r_out_req;
  assign out_data   = r_out_data;
  assign out_stream = r_stream;
  assign out_last   = r_last;

endmodule

// File: tb/tb_word_splitter_tagged.sv
// tb/tb_word_splitter_tagged.sv - bench for word_splitter_tagged with 36-stream and 3-stream instances
// A per-instance queue of pending samples predicts every output; directed literals pin key cases.
module tb_word_splitter_tagged;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic [1:0]  in_ack = 2'b00;
  logic [1:0]  out_ack = 2'b00;
  logic [31:0] idata [2];

  logic        in_req0, out_req0, olast0;
  logic [15:0] odata0;
  logic [5:0]  ostr0;
  logic        in_req1, out_req1, olast1;
  logic [15:0] odata1;
  logic [1:0]  ostr1;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc = 0;
  int nxfer [2] = '{0, 0};
  int nlast [2] = '{0, 0};
  int last_idx [2] = '{0, 0};
  logic [15:0] last_data [2];
  logic [5:0]  tagc [2] = '{6'd0, 6'd0};
  logic [21:0] q0 [$];
  logic [21:0] q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  word_splitter_tagged #(.DWIDTH(16), .C_SLV_DWIDTH(32), .NR_STREAMS(36), .NR_STREAMS_LOG(6)) dut36 (
    .clk(clk), .rst(rst[0]), .in_req(in_req0), .in_ack(in_ack[0]), .in_data(idata[0]),
    .out_req(out_req0), .out_ack(out_ack[0]), .out_data(odata0), .out_stream(ostr0), .out_last(olast0)
  );

  word_splitter_tagged #(.DWIDTH(16), .C_SLV_DWIDTH(32), .NR_STREAMS(3), .NR_STREAMS_LOG(2)) dut3 (
    .clk(clk), .rst(rst[1]), .in_req(in_req1), .in_ack(in_ack[1]), .in_data(idata[1]),
    .out_req(out_req1), .out_ack(out_ack[1]), .out_data(odata1), .out_stream(ostr1), .out_last(olast1)
  );

  function automatic int nstr(input int d);
    return (d == 0) ? 36 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic push_sample(input int d, input logic [15:0] data);
    if (d == 0) q0.push_back({tagc[d], data});
    else        q1.push_back({tagc[d], data});
    tagc[d] = (int'(tagc[d]) == nstr(d) - 1) ? 6'd0 : tagc[d] + 6'd1;
  endtask

  task automatic mon(input int d);
    int sz;
    logic [21:0] fr;
    logic ireq, oreq, olst, oack;
    logic [15:0] od;
    logic [5:0] os;
    sz   = (d == 0) ? q0.size() : q1.size();
    ireq = (d == 0) ? in_req0 : in_req1;
    oreq = (d == 0) ? out_req0 : out_req1;
    olst = (d == 0) ? olast0 : olast1;
    od   = (d == 0) ? odata0 : odata1;
    os   = (d == 0) ? ostr0 : {4'b0, ostr1};
    oack = out_ack[d];
    if (rst[d]) begin
      chk("rst_in_req", ireq, 0);
      chk("rst_out_req", oreq, 0);
      if (d == 0) q0.delete(); else q1.delete();
      tagc[d] = 6'd0;
      return;
    end
    chk("in_req", ireq, (sz == 0) || (sz == 1 && oack));
    chk("out_req", oreq, sz != 0);
    if (sz != 0) begin
      fr = (d == 0) ? q0[0] : q1[0];
      chk("out_data", od, fr[15:0]);
      chk("out_stream", os, fr[21:16]);
      chk("out_last", olst, int'(fr[21:16]) == nstr(d) - 1);
      if (oack) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    if (oreq && oack) begin
      nxfer[d]++;
      if (olst) begin
        nlast[d]++;
        last_data[d] = od;
        last_idx[d] = nxfer[d] - 1;
      end
    end
    if (ireq && in_ack[d]) begin
      push_sample(d, idata[d][31:16]);
      push_sample(d, idata[d][15:0]);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_ack = 2'b00;
    rst = 2'b11;
    tick;
    tick;
    rst = 2'b00;
  endtask

  task automatic send_word(input int d, input logic [31:0] w);
    bit ok;
    ok = 0;
    idata[d] = w;
    in_ack[d] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((d == 0) ? in_req0 : in_req1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_ack[d] = 1'b0;
    last_acc = cyc;
  endtask

  task automatic lit(input string nm, input logic req, input logic [15:0] data, input logic [5:0] tag);
    @(negedge clk);
    chk({nm, "_req"}, out_req0, req);
    if (req) begin
      chk({nm, "_data"}, odata0, data);
      chk({nm, "_tag"}, ostr0, tag);
    end
  endtask

  int pat [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  int first_acc, x0, l0;

  initial begin
    idata[0] = '0;
    idata[1] = '0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_out_req", out_req0, 0);
    chk("reset_out_data", odata0, 0);
    chk("reset_out_stream", ostr0, 0);
    chk("reset_out_last36", olast0, 0);
    chk("reset_out_last3", olast1, 0);
    chk("reset_in_req", in_req0, 0);
    do_reset;

    out_ack[0] = 1'b1;
    send_word(0, 32'h1234ABCD);
    lit("t1_hi", 1, 16'h1234, 0);
    tick;
    lit("t1_lo", 1, 16'hABCD, 1);
    tick;
    lit("t1_idle", 0, 16'h0, 0);
    chk("t1_idle_in_req", in_req0, 1);

    do_reset;
    out_ack[0] = 1'b0;
    send_word(0, 32'hDEAD0001);
    lit("t2_hold1", 1, 16'hDEAD, 0);
    chk("t2_in_req", in_req0, 0);
    tick;
    lit("t2_hold2", 1, 16'hDEAD, 0);
    tick;
    lit("t2_hold3", 1, 16'hDEAD, 0);
    tick;
    out_ack[0] = 1'b1;
    lit("t2_hold4", 1, 16'hDEAD, 0);
    tick;
    lit("t2_lo", 1, 16'h0001, 1);
    tick;

    do_reset;
    out_ack[0] = 1'b1;
    x0 = nxfer[0];
    l0 = nlast[0];
    first_acc = 0;
    for (int i = 0; i < 19; i++) begin
      send_word(0, {16'(16'h0100 + 2 * i), 16'(16'h0101 + 2 * i)});
      if (i == 0) first_acc = last_acc;
    end
    chk("t3_no_bubble", last_acc - first_acc, 36);
    repeat (3) tick;
    chk("t3_xfers", nxfer[0] - x0, 38);
    chk("t3_last_count", nlast[0] - l0, 1);
    chk("t3_last_index", last_idx[0] - x0, 35);

    do_reset;
    out_ack[1] = 1'b1;
    x0 = nxfer[1];
    send_word(1, 32'h00010002);
    send_word(1, 32'h00030004);
    repeat (3) tick;
    chk("t4_xfers", nxfer[1] - x0, 4);
    chk("t4_last_sample", last_data[1], 16'h0003);
    chk("t4_last_index", last_idx[1] - x0, 2);

    do_reset;
    out_ack[0] = 1'b0;
    send_word(0, 32'h55556666);
    out_ack[0] = 1'b1;
    tick;
    out_ack[0] = 1'b0;
    #1;
    chk("t5_lo_req", out_req0, 1);
    chk("t5_lo_data", odata0, 16'h6666);
    #1;
    rst[0] = 1'b1;
    #1;
    chk("t5_async_drop", out_req0, 0);
    tick;
    rst[0] = 1'b0;
    out_ack[0] = 1'b1;
    send_word(0, 32'h77778888);
    lit("t5_after", 1, 16'h7777, 0);
    tick;
    tick;

    do_reset;
    out_ack[0] = 1'b1;
    x0 = nxfer[0];
    for (int i = 0; i < 10; i++) begin
      in_ack[0] = pat[i][0];
      idata[0] = {16'(16'hA000 + i), 16'(16'hB000 + i)};
      tick;
    end
    in_ack[0] = 1'b0;
    repeat (3) tick;
    chk("t6_xfers", nxfer[0] - x0, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
